// File: rtl/falafel_req_scheduler.sv
// falafel_req_scheduler: drains the alloc and free request FIFOs and hands one
// request at a time to the allocator core, waiting for its completion before the
// next grant. Alloc wins arbitration, but only for a bounded streak while frees wait.
module falafel_req_scheduler #(
    parameter int DATA_W     = 16,
    parameter int STREAK_MAX = 4,
    parameter int CNT_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              alloc_fifo_empty_i,
    input  logic [DATA_W-1:0] alloc_fifo_dout_i,
    output logic              alloc_fifo_read_o,
    input  logic              free_fifo_empty_i,
    input  logic [DATA_W-1:0] free_fifo_dout_i,
    output logic              free_fifo_read_o,
    output logic              core_req_val_o,
    input  logic              core_req_rdy_i,
    output logic              core_req_free_o,
    output logic [DATA_W-1:0] core_req_data_o,
    input  logic              core_rsp_val_i,
    output logic              core_rsp_rdy_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  alloc_grants_o,
    output logic [CNT_W-1:0]  free_grants_o
);

    localparam int SW = $clog2(STREAK_MAX + 1);
    localparam logic [SW-1:0] STREAK_SAT = SW'(STREAK_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [SW-1:0]     r_streak;
    logic [DATA_W-1:0] r_data;
    logic              r_kind;
    logic [CNT_W-1:0]  r_alloc_cnt;
    logic [CNT_W-1:0]  r_free_cnt;
    logic              w_grant_free;
    logic              w_grant_alloc;
    logic              w_accept;

    // Arbitration in IDLE; gated by reset so no pop escapes while reset is held.
    always_comb begin
        w_grant_free  = 1'b0;
        w_grant_alloc = 1'b0;
        if (rst_ni && (r_state == S_IDLE)) begin
            w_grant_free  = !free_fifo_empty_i &&
                            (alloc_fifo_empty_i || (r_streak == STREAK_SAT));
            w_grant_alloc = !alloc_fifo_empty_i && !w_grant_free;
        end
        w_accept = (r_state == S_ISSUE) && core_req_rdy_i;
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state and handshake outputs; an illegal encoding falls back to IDLE.
    always_comb begin
        w_next            = r_state;
        alloc_fifo_read_o = 1'b0;
        free_fifo_read_o  = 1'b0;
        core_req_val_o    = 1'b0;
        core_rsp_rdy_o    = 1'b0;
        busy_o            = 1'b0;
        case (r_state)
            S_IDLE: begin
                alloc_fifo_read_o = w_grant_alloc;
                free_fifo_read_o  = w_grant_free;
                if (w_grant_alloc || w_grant_free) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                core_req_val_o = 1'b1;
                busy_o         = 1'b1;
                if (core_req_rdy_i) w_next = S_WAIT;
            end
            S_WAIT: begin
                core_rsp_rdy_o = 1'b1;
                busy_o         = 1'b1;
                if (core_rsp_val_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Latch payload/kind on grant and track the consecutive-alloc streak.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_streak <= '0;
            r_data   <= '0;
            r_kind   <= 1'b0;
        end else if (w_grant_free) begin
            r_streak <= '0;
            r_data   <= free_fifo_dout_i;
            r_kind   <= 1'b1;
        end else if (w_grant_alloc) begin
            if (r_streak != STREAK_SAT) r_streak <= r_streak + 1'b1;
            r_data <= alloc_fifo_dout_i;
            r_kind <= 1'b0;
        end
    end

    // Grant counters advance only on the cycle the core accepts the request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_alloc_cnt <= '0;
            r_free_cnt  <= '0;
        end else if (w_accept) begin
            if (r_kind) r_free_cnt  <= r_free_cnt + 1'b1;
            else        r_alloc_cnt <= r_alloc_cnt + 1'b1;
        end
    end

    assign core_req_data_o = r_data;
    assign core_req_free_o = r_kind;
    assign alloc_grants_o  = r_alloc_cnt;
    assign free_grants_o   = r_free_cnt;

    a_state_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_state inside {S_IDLE, S_ISSUE, S_WAIT});

endmodule

// File: tb/tb_falafel_req_scheduler.sv
// Bench for falafel_req_scheduler: FIFO/core environment, transaction-level model,
// directed scenarios and a randomized run.
module tb_falafel_req_scheduler;
    localparam int DATA_W     = 16;
    localparam int STREAK_MAX = 4;
    localparam int CNT_W      = 4;
    localparam int CNT_MOD    = 1 << CNT_W;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              alloc_fifo_empty_i;
    logic [DATA_W-1:0] alloc_fifo_dout_i;
    logic              alloc_fifo_read_o;
    logic              free_fifo_empty_i;
    logic [DATA_W-1:0] free_fifo_dout_i;
    logic              free_fifo_read_o;
    logic              core_req_val_o;
    logic              core_req_rdy_i = 1'b0;
    logic              core_req_free_o;
    logic [DATA_W-1:0] core_req_data_o;
    logic              core_rsp_val_i = 1'b0;
    logic              core_rsp_rdy_o;
    logic              busy_o;
    logic [CNT_W-1:0]  alloc_grants_o;
    logic [CNT_W-1:0]  free_grants_o;

    falafel_req_scheduler #(.DATA_W(DATA_W), .STREAK_MAX(STREAK_MAX), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .alloc_fifo_empty_i(alloc_fifo_empty_i), .alloc_fifo_dout_i(alloc_fifo_dout_i),
        .alloc_fifo_read_o(alloc_fifo_read_o),
        .free_fifo_empty_i(free_fifo_empty_i), .free_fifo_dout_i(free_fifo_dout_i),
        .free_fifo_read_o(free_fifo_read_o),
        .core_req_val_o(core_req_val_o), .core_req_rdy_i(core_req_rdy_i),
        .core_req_free_o(core_req_free_o), .core_req_data_o(core_req_data_o),
        .core_rsp_val_i(core_rsp_val_i), .core_rsp_rdy_o(core_rsp_rdy_o),
        .busy_o(busy_o), .alloc_grants_o(alloc_grants_o), .free_grants_o(free_grants_o)
    );

    initial forever #5 clk_i = ~clk_i;

    // Environment FIFOs (contents are not affected by scheduler reset).
    logic [DATA_W-1:0] aq[$];
    logic [DATA_W-1:0] fq[$];

    // Transaction model: phase 0 = nothing outstanding, 1 = request offered, 2 = awaiting completion.
    int                m_phase;
    bit                m_kind;
    logic [DATA_W-1:0] m_data;
    int                m_streak;
    int                m_acnt;
    int                m_fcnt;

    // Values captured at the sampling edge, consumed at the next active edge.
    bit                e_pa, e_pf, s_pa, s_pf, s_rdy, s_rsp;
    logic [DATA_W-1:0] h_a, h_f;
    bit                dut_log[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic refresh();
        alloc_fifo_empty_i = (aq.size() == 0);
        alloc_fifo_dout_i  = (aq.size() != 0) ? aq[0] : '0;
        free_fifo_empty_i  = (fq.size() == 0);
        free_fifo_dout_i   = (fq.size() != 0) ? fq[0] : '0;
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_kind   = 1'b0;
        m_data   = '0;
        m_streak = 0;
        m_acnt   = 0;
        m_fcnt   = 0;
        e_pa = 0; e_pf = 0; s_pa = 0; s_pf = 0; s_rdy = 0; s_rsp = 0;
    endtask

    // One clock: advance the model and the FIFOs at the edge, then settle new inputs.
    task automatic tick();
        @(posedge clk_i);
        if (rst_ni) begin
            case (m_phase)
                0: begin
                    if (e_pf) begin
                        m_phase = 1; m_kind = 1'b1; m_data = h_f; m_streak = 0;
                    end else if (e_pa) begin
                        m_phase = 1; m_kind = 1'b0; m_data = h_a;
                        if (m_streak < STREAK_MAX) m_streak++;
                    end
                end
                1: begin
                    if (s_rdy) begin
                        if (m_kind) m_fcnt++;
                        else        m_acnt++;
                        m_phase = 2;
                    end
                end
                default: if (s_rsp) m_phase = 0;
            endcase
            if (s_pa && aq.size() != 0) void'(aq.pop_front());
            if (s_pf && fq.size() != 0) void'(fq.pop_front());
        end
        #2;
        refresh();
    endtask

    // Compare process: checks every DUT output against the model on each falling edge.
    initial forever begin
        @(negedge clk_i);
        if (!rst_ni) begin
            chk("rst_pop_alloc", alloc_fifo_read_o, 0);
            chk("rst_pop_free", free_fifo_read_o, 0);
            chk("rst_req_val", core_req_val_o, 0);
            chk("rst_req_data", core_req_data_o, 0);
            chk("rst_busy", busy_o, 0);
            chk("rst_alloc_grants", alloc_grants_o, 0);
            chk("rst_free_grants", free_grants_o, 0);
            s_pa = 0; s_pf = 0; e_pa = 0; e_pf = 0;
        end else begin
            e_pf = (m_phase == 0) && (fq.size() != 0) &&
                   ((aq.size() == 0) || (m_streak == STREAK_MAX));
            e_pa = (m_phase == 0) && (aq.size() != 0) && !e_pf;
            h_a  = (aq.size() != 0) ? aq[0] : '0;
            h_f  = (fq.size() != 0) ? fq[0] : '0;
            chk("pop_alloc", alloc_fifo_read_o, e_pa);
            chk("pop_free", free_fifo_read_o, e_pf);
            chk("req_val", core_req_val_o, m_phase == 1);
            chk("rsp_rdy", core_rsp_rdy_o, m_phase == 2);
            chk("busy", busy_o, m_phase != 0);
            chk("alloc_grants", alloc_grants_o, 32'(m_acnt % CNT_MOD));
            chk("free_grants", free_grants_o, 32'(m_fcnt % CNT_MOD));
            if (m_phase == 1) begin
                chk("req_data", core_req_data_o, m_data);
                chk("req_kind", core_req_free_o, m_kind);
            end
            s_pa  = alloc_fifo_read_o;
            s_pf  = free_fifo_read_o;
            s_rdy = core_req_rdy_i;
            s_rsp = core_rsp_val_i;
            if ((s_pa && aq.size() == 0) || (s_pf && fq.size() == 0)) begin
                checks++; errors++;
                $display("FAIL pop_empty: pop_alloc=%0d pop_free=%0d with empty FIFO", s_pa, s_pf);
            end
            if (core_req_val_o && core_req_rdy_i) dut_log.push_back(core_req_free_o);
        end
    end

    task automatic do_reset();
        #1 rst_ni = 1'b0;
        model_reset();
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic drain(input int limit, input bit rnd);
        int n;
        n = 0;
        while ((aq.size() != 0 || fq.size() != 0 || m_phase != 0) && n < limit) begin
            if (rnd) begin
                core_req_rdy_i = ($urandom_range(0, 1) == 1);
                core_rsp_val_i = ($urandom_range(0, 2) == 0);
            end
            tick();
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL drain_timeout: %0d cycles used, limit %0d", n, limit);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    bit t3_exp[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        model_reset();
        refresh();
        tick();
        tick();
        rst_ni = 1'b1;
        #1;
        chk("init_alloc_grants", alloc_grants_o, 0);
        chk("init_free_grants", free_grants_o, 0);
        chk("init_busy", busy_o, 0);

        // Single alloc: pop at c0, request at c1, one grant, response three cycles later.
        core_req_rdy_i = 1'b1; core_rsp_val_i = 1'b0;
        aq.push_back(16'h0040); refresh();
        #1;
        chk("t2_pop_c0", alloc_fifo_read_o, 1);
        chk("t2_val_c0", core_req_val_o, 0);
        tick(); #1;
        chk("t2_val_c1", core_req_val_o, 1);
        chk("t2_data_c1", core_req_data_o, 16'h0040);
        chk("t2_kind_c1", core_req_free_o, 0);
        tick(); #1;
        chk("t2_grants", alloc_grants_o, 1);
        chk("t2_wait", core_rsp_rdy_o, 1);
        tick(); tick();
        core_rsp_val_i = 1'b1;
        tick();
        core_rsp_val_i = 1'b0;
        #1;
        chk("t2_idle", busy_o, 0);

        // Starvation bound: 8 allocs + 1 free queued together.
        do_reset();
        dut_log.delete();
        core_req_rdy_i = 1'b1; core_rsp_val_i = 1'b1;
        for (int i = 0; i < 8; i++) aq.push_back(DATA_W'(16'h0100 + i));
        fq.push_back(16'h0200);
        refresh();
        drain(200, 1'b0);
        #1;
        chk("t3_count", dut_log.size(), 9);
        for (int i = 0; i < 9 && i < dut_log.size(); i++) chk("t3_order", dut_log[i], t3_exp[i]);
        chk("t3_free_grants", free_grants_o, 1);
        chk("t3_alloc_grants", alloc_grants_o, 8);

        // Backpressure: streak is saturated, so the queued free goes first and is held.
        core_req_rdy_i = 1'b0; core_rsp_val_i = 1'b0;
        aq.push_back(16'h0055); fq.push_back(16'h0066); refresh();
        tick(); #1;
        chk("t4_first_free", core_req_free_o, 1);
        for (int i = 0; i < 10; i++) begin
            tick(); #1;
            chk("t4_hold_val", core_req_val_o, 1);
            chk("t4_hold_data", core_req_data_o, 16'h0066);
            chk("t4_hold_kind", core_req_free_o, 1);
            chk("t4_no_pop", alloc_fifo_read_o, 0);
            chk("t4_cnt_hold", free_grants_o, 1);
        end
        core_req_rdy_i = 1'b1;
        tick(); #1;
        chk("t4_cnt_accept", free_grants_o, 2);
        core_rsp_val_i = 1'b1;
        drain(50, 1'b0);

        // Response gating: responses outside WAIT are ignored.
        core_req_rdy_i = 1'b0; core_rsp_val_i = 1'b1;
        tick(); #1;
        chk("t5_idle_ignore", busy_o, 0);
        core_rsp_val_i = 1'b0;
        aq.push_back(16'h0077); refresh();
        tick();
        core_rsp_val_i = 1'b1;
        tick(); #1;
        chk("t5_issue_ignore", core_req_val_o, 1);
        core_rsp_val_i = 1'b0; core_req_rdy_i = 1'b1;
        aq.push_back(16'h0078); refresh();
        tick();
        core_req_rdy_i = 1'b0;
        #1;
        chk("t5_wait", core_rsp_rdy_o, 1);
        chk("t5_wait_no_pop", alloc_fifo_read_o, 0);
        tick(); #1;
        chk("t5_wait_no_pop2", alloc_fifo_read_o, 0);
        core_rsp_val_i = 1'b1;
        tick();
        core_rsp_val_i = 1'b0;
        #1;
        chk("t5_regrant", alloc_fifo_read_o, 1);
        core_req_rdy_i = 1'b1; core_rsp_val_i = 1'b1;
        drain(50, 1'b0);

        // Asynchronous reset in the middle of WAIT.
        core_req_rdy_i = 1'b1; core_rsp_val_i = 1'b0;
        aq.push_back(16'h0099); refresh();
        tick(); tick();
        aq.push_back(16'h009A); fq.push_back(16'h009B); refresh();
        #1;
        chk("t1_in_wait", core_rsp_rdy_o, 1);
        rst_ni = 1'b0;
        model_reset();
        #1;
        chk("t1_pop_alloc", alloc_fifo_read_o, 0);
        chk("t1_pop_free", free_fifo_read_o, 0);
        chk("t1_val", core_req_val_o, 0);
        chk("t1_kind", core_req_free_o, 0);
        chk("t1_data", core_req_data_o, 0);
        chk("t1_rsp_rdy", core_rsp_rdy_o, 0);
        chk("t1_busy", busy_o, 0);
        chk("t1_alloc_grants", alloc_grants_o, 0);
        chk("t1_free_grants", free_grants_o, 0);
        tick(); tick();
        rst_ni = 1'b1;
        #1;
        chk("t1_post_alloc_grants", alloc_grants_o, 0);
        chk("t1_post_free_grants", free_grants_o, 0);
        chk("t1_post_idle_pop", alloc_fifo_read_o, 1);
        core_rsp_val_i = 1'b1;
        drain(50, 1'b0);

        // Counter wrap with a 4-bit counter: 17 frees.
        do_reset();
        core_req_rdy_i = 1'b1; core_rsp_val_i = 1'b1;
        for (int i = 0; i < 17; i++) fq.push_back(DATA_W'(16'h0300 + i));
        refresh();
        drain(300, 1'b0);
        #1;
        chk("t6_free_wrap", free_grants_o, 1);
        chk("t6_alloc_none", alloc_grants_o, 0);

        // Randomized traffic, with one reset dropped in mid-run.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0 && aq.size() < 8) aq.push_back(DATA_W'($urandom));
            if ($urandom_range(0, 5) == 0 && fq.size() < 8) fq.push_back(DATA_W'($urandom));
            core_req_rdy_i = ($urandom_range(0, 1) == 1);
            core_rsp_val_i = ($urandom_range(0, 2) == 0);
            refresh();
            if (i == 1500) begin
                #1 rst_ni = 1'b0;
                model_reset();
                tick();
                tick();
                rst_ni = 1'b1;
            end
            tick();
        end
        drain(2000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
